// File: rtl/jpeg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_arb_pkg
// Purpose  : Shared types and constants for the JPEG block arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package jpeg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_PAD     = 2'd2
    } arb_state_t;

    localparam logic [1:0] CH_Y  = 2'b00;
    localparam logic [1:0] CH_CB = 2'b01;
    localparam logic [1:0] CH_CR = 2'b10;

    localparam int DEF_PIXEL_COUNT = 64;

endpackage
`default_nettype wire

// File: rtl/jpeg_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_arb_id_fifo
// Purpose  : In-order FIFO of granted source IDs; head tags the result stream.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_arb_id_fifo
    import jpeg_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_idx(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_idx(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/jpeg_block_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_block_arbiter
// Purpose  : Round-robin 8x8-block arbiter sharing one JPEG engine; tags the
//            result stream with the owning source ID. Optional stall
//            watchdog/padding enabled by macro JPEG_ARB_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_block_arbiter
    import jpeg_arb_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int INPUT_WIDTH   = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int PIXEL_COUNT   = DEF_PIXEL_COUNT,
    parameter int ID_FIFO_DEPTH = 2,
    parameter int WDOG_CYCLES   = 256
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_SRC*3*INPUT_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]               s_axis_tvalid,
    input  logic [NUM_SRC-1:0]               s_axis_tlast,
    output logic [NUM_SRC-1:0]               s_axis_tready,
    output logic [3*INPUT_WIDTH-1:0]         e_tdata,
    output logic                             e_tvalid,
    output logic                             e_tlast,
    input  logic                             e_tready,
    input  logic [DATA_WIDTH-1:0]            r_tdata,
    input  logic                             r_tvalid,
    input  logic                             r_tlast,
    input  logic [1:0]                       r_tuser,
    output logic                             r_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    output logic [1:0]                       m_axis_tuser,
    input  logic                             m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]       m_axis_tdest,
    output logic                             busy,
    output logic                             err_framing,
    output logic                             err_orphan,
    output logic                             err_pad
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = 3 * INPUT_WIDTH;
    localparam int BW = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PIXEL_COUNT - 1);

    if (NUM_SRC < 2 || PIXEL_COUNT < 2 || ID_FIFO_DEPTH < 1 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("jpeg_block_arbiter: illegal parameter set");
    end

    arb_state_t     state;
    logic [SW-1:0]  grant;
    logic [SW-1:0]  rr_ptr;
    logic [SW-1:0]  pick;
    logic           pick_ok;
    logic [BW-1:0]  beat;
    logic [PW-1:0]  grant_slice;
    logic           src_valid;
    logic           hs;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [SW-1:0]  fifo_head;

    // Scan from farthest to nearest so the source closest after rr_ptr wins.
    always_comb begin
        logic [SW-1:0] idx;
        idx     = '0;
        pick    = rr_ptr;
        pick_ok = 1'b0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = SW'((int'(rr_ptr) + i) % NUM_SRC);
            if (s_axis_tvalid[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        grant_slice = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant == SW'(k)) begin
                grant_slice = s_axis_tdata[k*PW +: PW];
            end
        end
    end

    assign src_valid = s_axis_tvalid[grant];

    always_comb begin
        s_axis_tready = '0;
        e_tvalid      = 1'b0;
        e_tdata       = '0;
        case (state)
            ST_FORWARD: begin
                e_tdata              = grant_slice;
                e_tvalid             = src_valid;
                s_axis_tready[grant] = e_tready;
            end
`ifdef JPEG_ARB_WDOG_EN
            ST_PAD: begin
                e_tvalid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign e_tlast     = (state != ST_IDLE) && (beat == LAST_BEAT);
    assign hs          = e_tvalid && e_tready;
    assign err_framing = (state == ST_FORWARD) && hs && (s_axis_tlast[grant] != e_tlast);
    assign push        = (state == ST_IDLE) && pick_ok && !fifo_full;
    assign busy        = (state != ST_IDLE) || !fifo_empty;

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign r_tready      = m_axis_tready;
    assign m_axis_tdest  = fifo_empty ? '0 : fifo_head;
    assign pop           = r_tvalid && m_axis_tready && r_tlast && (r_tuser == CH_CR) && !fifo_empty;
    // Orphan beats seen while held in reset are not errors.
    assign err_orphan    = reset_n && r_tvalid && fifo_empty;

`ifdef JPEG_ARB_WDOG_EN
    localparam int SCW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [SCW-1:0] STALL_LAST = SCW'(WDOG_CYCLES - 1);
    logic [SCW-1:0] stall;
`else
    assign err_pad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= SW'(NUM_SRC - 1);
            beat   <= '0;
`ifdef JPEG_ARB_WDOG_EN
            stall   <= '0;
            err_pad <= 1'b0;
`endif
        end else begin
`ifdef JPEG_ARB_WDOG_EN
            err_pad <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (push) begin
                        grant  <= pick;
                        rr_ptr <= pick;
                        beat   <= '0;
                        state  <= ST_FORWARD;
`ifdef JPEG_ARB_WDOG_EN
                        stall  <= '0;
`endif
                    end
                end
                ST_FORWARD: begin
                    if (hs) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
`ifdef JPEG_ARB_WDOG_EN
                        stall <= '0;
                    end else if (!src_valid) begin
                        if (stall == STALL_LAST) begin
                            stall   <= '0;
                            err_pad <= 1'b1;
                            state   <= ST_PAD;
                        end else begin
                            stall <= stall + 1'b1;
                        end
`endif
                    end
                end
`ifdef JPEG_ARB_WDOG_EN
                ST_PAD: begin
                    if (hs) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    jpeg_arb_id_fifo #(
        .DEPTH (ID_FIFO_DEPTH),
        .WIDTH (SW)
    ) u_id_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (pick),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
`default_nettype wire

// File: doc/jpeg_block_arbiter.md
# jpeg_block_arbiter

Shares one `jpeg_compression_pipeline_axi_stream` engine between `NUM_SRC` RGB pixel-stream requesters. Arbitration is round-robin at 8x8-block granularity: a granted source owns the engine input for exactly `PIXEL_COUNT` beats. The block records each granted source ID in an in-order FIFO. It tags the engine's Y/Cb/Cr result stream with the owning source ID on `m_axis_tdest`. It sits between the DMA/tiler front-ends and the compression engine.

## Interface
- `NUM_SRC`, 4: number of requesters; must be at least 2.
- `INPUT_WIDTH`, 8: width of one colour component.
- `DATA_WIDTH`, 32: width of an engine result word.
- `PIXEL_COUNT`, 64: beats per block.
- `ID_FIFO_DEPTH`, 2: maximum number of blocks granted but not yet fully output.
- `WDOG_CYCLES`, 256: stall limit in cycles; used only with `JPEG_ARB_WDOG_EN`.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in `NUM_SRC*3*INPUT_WIDTH`: per-source RGB beats; source k occupies slice k.
- `s_axis_tvalid`, `s_axis_tlast` in `NUM_SRC`: per-source valid and last.
- `s_axis_tready` out `NUM_SRC`: per-source ready.
- `e_tdata` out `3*INPUT_WIDTH`, `e_tvalid` out 1, `e_tlast` out 1, `e_tready` in 1: engine input stream.
- `r_tdata` in `DATA_WIDTH`, `r_tvalid` in 1, `r_tlast` in 1, `r_tuser` in 2, `r_tready` out 1: engine result stream.
- `m_axis_tdata` out `DATA_WIDTH`, `m_axis_tvalid` out 1, `m_axis_tlast` out 1, `m_axis_tuser` out 2, `m_axis_tready` in 1: tagged result stream.
- `m_axis_tdest` out `$clog2(NUM_SRC)`: owning source ID.
- `busy` out 1: high when not in IDLE or when the ID FIFO is non-empty.
- `err_framing` out 1: one-cycle error pulse.
- `err_orphan` out 1: one-cycle error pulse.
- `err_pad` out 1: one-cycle error pulse.

## Operation
- States are IDLE, FORWARD and PAD. PAD exists only with the macro.
- **IDLE**
  - If any `s_axis_tvalid` is high and the ID FIFO is not full, pick the first valid source after `rr_ptr`, cyclically.
  - Register the pick as `grant`, push `grant` to the ID FIFO, set `rr_ptr` to `grant`, clear `beat`, and go to FORWARD.
  - All `s_axis_tready` are 0. `e_tvalid` = 0. `e_tdata` = 0.
- **FORWARD**
  - `e_tdata` = slice `grant`. `e_tvalid` = `s_axis_tvalid[grant]`. `s_axis_tready[grant]` = `e_tready`. All other readies are 0.
  - `e_tlast` = (`beat` == `PIXEL_COUNT-1`).
  - On each handshake, `beat` increments.
  - On the handshake with `beat` == `PIXEL_COUNT-1`, return to IDLE.
  - Block length is set by the counter only; source `tlast` never ends a block.
- **Framing check:** pulse `err_framing` on any handshake where `s_axis_tlast[grant]` != `e_tlast`.
- **Result path** is combinational pass-through:
  - `m_axis_tdata/tvalid/tlast/tuser` = `r_*`.
  - `r_tready` = `m_axis_tready`.
  - `m_axis_tdest` = ID FIFO head, or 0 when the FIFO is empty.
- **Pop:** pop the ID FIFO on a result handshake with `r_tlast` = 1 and `r_tuser` = 2'b10 (last Cr beat).
- **Orphan result:** pulse `err_orphan` if `r_tvalid` = 1 while the FIFO is empty. The beat still passes, with `tdest` = 0.
- **Simultaneous push and pop** is legal. A push while the FIFO is full cannot occur, because a grant requires not-full.

## Timing
- **Reset values:** state = IDLE, `rr_ptr` = `NUM_SRC-1` (source 0 wins first), FIFO empty, `beat` = 0, all `s_axis_tready` = 0, `e_tvalid` = `e_tlast` = 0, `e_tdata` = 0, `busy` = 0, all `err_*` = 0.
  - `m_axis_*` follow `r_*` even during reset; `m_axis_tdest` = 0.
- **Arbitration latency:** 1 cycle. A valid request seen in IDLE gives the first forwardable beat on the next cycle. This makes a 1-cycle bubble between blocks.
- **Throughput:** `PIXEL_COUNT`+1 cycles per block at full rate.
- **Datapath latency:** no registers on the forwarded data or result path; added latency is 0 cycles.
- **Reset mid-block:** everything returns to reset values immediately. The engine shares `reset_n`, and the partial block is discarded.

## Configuration
- **`JPEG_ARB_WDOG_EN` defined:**
  - In FORWARD, a stall counter increments on every cycle with `s_axis_tvalid[grant]` = 0 and clears on any handshake.
  - When it reaches `WDOG_CYCLES`, go to PAD and pulse `err_pad` for one cycle.
  - In PAD: `e_tvalid` = 1, `e_tdata` = 0, `s_axis_tready[grant]` = 0. `beat` continues until `PIXEL_COUNT-1` is accepted, then go to IDLE.
  - The ID remains queued, and the padded block is output normally.
- **`JPEG_ARB_WDOG_EN` undefined:** no counter and no PAD state. FORWARD waits indefinitely. `err_pad` is tied to 0.

## Structure
- **Package `jpeg_arb_pkg`:** state enum; channel codes `CH_Y` = 2'b00, `CH_CB` = 2'b01, `CH_CR` = 2'b10; default `PIXEL_COUNT`.
- **Sub-module `jpeg_arb_id_fifo`:**
  - Synchronous FIFO of depth `ID_FIFO_DEPTH` and width `$clog2(NUM_SRC)`.
  - Ports: `push`, `pop`, `din`, `dout` (head), `full`, `empty`.
  - Asynchronous reset to empty.

## Test plan
- **Single source:** source 0 sends 64 beats while the engine returns 192 beats -> `e_tlast` on beat 64 only, `m_axis_tdest` = 0 on all 192 beats, FIFO empty and `busy` = 0 afterwards.
- **Round-robin:** sources 1 and 3 continuously valid from reset -> grant order 1, 3, 1, 3, with one idle cycle between blocks.
- **Backpressure:** `ID_FIFO_DEPTH` = 2 with `m_axis_tready` held at 0 -> two blocks forwarded, third withheld; after the first block's Cr `tlast` handshake, the third grant is issued next cycle.
- **Framing error:** source 2 asserts `tlast` on beat 10 -> `err_framing` pulses at that beat and at beat 64; the block is still 64 beats.
- **Watchdog** (`JPEG_ARB_WDOG_EN`, `WDOG_CYCLES` = 16): source 2 stops after beat 20 -> after 16 stall cycles, `err_pad` pulses once, beats 21-64 carry `e_tdata` = 0, `s_axis_tready[2]` = 0 throughout PAD.
- **Reset mid-block:** `reset_n` low at beat 30 -> all outputs at reset values; after release, source 0 is granted first.
